// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequencer and arbiter for the single-port unified memory
// shared by instruction fetch and the memory stage (LDR/STR).
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   if_req/if_addr       fetch read request (held until if_ready)
//   if_ready/if_rdata    fetch completion pulse and registered read word
//   dm_req/dm_we/...     data request (load or store, held until dm_ready)
//   dm_ready/dm_rdata    data completion pulse and registered load word
//   mem_en/mem_we/...    RAM strobe, write enable, address, write data
//   mem_rdata            RAM read data, valid MEM_LATENCY cycles after mem_en
//   sel_stall            pipeline stall while any request is outstanding
//   busy                 arbiter is not idle
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY   = 2,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        sel_stall,
  output logic        busy
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned STREAK_W = 4;
  localparam logic [CNT_W-1:0]    LAT_INIT   = CNT_W'(MEM_LATENCY);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t              state;
  logic                owner_dm;
  logic                lat_we;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;
  logic                grant_dm_c;

  // Data wins a tie unless it has already starved fetch for MAX_DM_STREAK grants.
  assign grant_dm_c = dm_req & (~if_req | (streak != STREAK_MAX));

  // Stall while any requester is waiting for its completion pulse.
  assign sel_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  // Sequencer: arbitration, RAM strobe, latency countdown and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      streak    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            // mem_addr/mem_wdata double as the winner's address/data latches.
            owner_dm  <= grant_dm_c;
            lat_we    <= grant_dm_c & dm_we;
            mem_en    <= 1'b1;
            mem_we    <= grant_dm_c & dm_we;
            mem_addr  <= grant_dm_c ? dm_addr : if_addr;
            mem_wdata <= grant_dm_c ? dm_wdata : '0;
            // Count only data grants that made a waiting fetch wait longer.
            if (grant_dm_c && if_req) begin
              if (streak < STREAK_MAX) streak <= streak + STREAK_W'(1);
            end else begin
              streak <= '0;
            end
            state <= ACCESS;
            busy  <= 1'b1;
          end
        end
        ACCESS: begin
          if (lat_we) begin
            dm_ready <= 1'b1;
            state    <= DONE;
          end else begin
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          // Last wait cycle lines up with mem_rdata becoming valid.
          if (cnt == CNT_W'(1)) begin
            if (owner_dm) begin
              dm_rdata <= mem_rdata;
              dm_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Three instances share stimulus and
// differ in MEM_LATENCY (2, 1, 7); each has its own fixed-latency RAM model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  logic        if_ready2, dm_ready2, mem_en2, mem_we2, sel_stall2, busy2;
  logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        if_ready1, dm_ready1, mem_en1, mem_we1, sel_stall1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ready7, dm_ready7, mem_en7, mem_we7, sel_stall7, busy7;
  logic [31:0] if_rdata7, dm_rdata7, mem_addr7, mem_wdata7, mem_rdata7;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.MEM_LATENCY(2), .MAX_DM_STREAK(4)) u_dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready2), .if_rdata(if_rdata2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready2), .dm_rdata(dm_rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .sel_stall(sel_stall2), .busy(busy2)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DM_STREAK(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .sel_stall(sel_stall1), .busy(busy1)
  );

  mem_port_arbiter #(.MEM_LATENCY(7), .MAX_DM_STREAK(4)) u_dut7 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready7), .if_rdata(if_rdata7),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready7), .dm_rdata(dm_rdata7),
    .mem_en(mem_en7), .mem_we(mem_we7), .mem_addr(mem_addr7), .mem_wdata(mem_wdata7),
    .mem_rdata(mem_rdata7), .sel_stall(sel_stall7), .busy(busy7)
  );

  // RAM contents: one fixed word at 0x100, otherwise derived from the address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hE3A0_1005;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Fixed-latency read pipelines; data is only valid in the exact cycle.
  logic [7:1]  v2, v1, v7;
  logic [31:0] d2 [1:7];
  logic [31:0] d1 [1:7];
  logic [31:0] d7 [1:7];

  initial begin
    v2 = '0; v1 = '0; v7 = '0;
  end

  always @(posedge clk) begin
    v2 <= {v2[6:1], mem_en2 & ~mem_we2};
    v1 <= {v1[6:1], mem_en1 & ~mem_we1};
    v7 <= {v7[6:1], mem_en7 & ~mem_we7};
    d2[1] <= ram_word(mem_addr2);
    d1[1] <= ram_word(mem_addr1);
    d7[1] <= ram_word(mem_addr7);
    for (int i = 2; i <= 7; i++) begin
      d2[i] <= d2[i-1];
      d1[i] <= d1[i-1];
      d7[i] <= d7[i-1];
    end
  end

  assign mem_rdata2 = v2[2] ? d2[2] : 32'hBAD0_BAD0;
  assign mem_rdata1 = v1[1] ? d1[1] : 32'hBAD0_BAD0;
  assign mem_rdata7 = v7[7] ? d7[7] : 32'hBAD0_BAD0;

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%h want=0", busy2); end
    checks++; if (mem_en2 !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%h want=0", mem_en2); end
    checks++; if (if_ready2 !== 1'b0 || dm_ready2 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%h%h want=00", if_ready2, dm_ready2); end
    checks++; if (if_rdata2 !== 32'h0 || dm_rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata2, dm_rdata2); end
    checks++; if (sel_stall2 !== 1'b0) begin failures++; $display("FAIL reset_stall got=%h want=0", sel_stall2); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    if_addr = 32'h0000_0100; if_req = 1'b1; #1;
    checks++; if (sel_stall2 !== 1'b1) begin failures++; $display("FAIL fetch_stall_t got=%h want=1", sel_stall2); end
    @(negedge clk); // t+1
    checks++; if (mem_en2 !== 1'b1 || mem_we2 !== 1'b0) begin failures++; $display("FAIL fetch_access got en=%h we=%h want en=1 we=0", mem_en2, mem_we2); end
    checks++; if (mem_addr2 !== 32'h0000_0100) begin failures++; $display("FAIL fetch_addr got=%h want=00000100", mem_addr2); end
    @(negedge clk); // t+2
    checks++; if (mem_en2 !== 1'b0 || sel_stall2 !== 1'b1) begin failures++; $display("FAIL fetch_t2 got en=%h stall=%h want en=0 stall=1", mem_en2, sel_stall2); end
    @(negedge clk); // t+3
    checks++; if (if_ready2 !== 1'b0 || sel_stall2 !== 1'b1) begin failures++; $display("FAIL fetch_t3 got rdy=%h stall=%h want rdy=0 stall=1", if_ready2, sel_stall2); end
    @(negedge clk); // t+4
    checks++; if (if_ready2 !== 1'b1) begin failures++; $display("FAIL fetch_ready got=%h want=1", if_ready2); end
    checks++; if (if_rdata2 !== 32'hE3A0_1005) begin failures++; $display("FAIL fetch_rdata got=%h want=e3a01005", if_rdata2); end
    checks++; if (sel_stall2 !== 1'b0) begin failures++; $display("FAIL fetch_stall_t4 got=%h want=0", sel_stall2); end
    if_req = 1'b0;
    @(negedge clk); // t+5
    checks++; if (if_ready2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL fetch_t5 got rdy=%h busy=%h want 0 0", if_ready2, busy2); end
  endtask

  task automatic test_load_during_fetch();
    logic exp_en;
    if_addr = 32'h0000_0104; if_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_en = (k == 1) || (k == 6);
      checks++; if (mem_en2 !== exp_en) begin failures++; $display("FAIL ldf_mem_en k=%0d got=%h want=%h", k, mem_en2, exp_en); end
      if (k == 2) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_3000;
      end
      if (k == 4) begin
        checks++; if (if_ready2 !== 1'b1 || dm_ready2 !== 1'b0) begin failures++; $display("FAIL ldf_fetch_ready got if=%h dm=%h want 1 0", if_ready2, dm_ready2); end
        checks++; if (if_rdata2 !== 32'h5B5E_0104) begin failures++; $display("FAIL ldf_fetch_rdata got=%h want=5b5e0104", if_rdata2); end
        if_req = 1'b0;
      end
      if (k == 5) begin
        checks++; if (sel_stall2 !== 1'b1 || busy2 !== 1'b0) begin failures++; $display("FAIL ldf_idle got stall=%h busy=%h want 1 0", sel_stall2, busy2); end
      end
      if (k == 6) begin
        checks++; if (mem_addr2 !== 32'h0000_3000 || mem_we2 !== 1'b0) begin failures++; $display("FAIL ldf_data_access got addr=%h we=%h want 00003000 0", mem_addr2, mem_we2); end
      end
      if (k == 9) begin
        checks++; if (dm_ready2 !== 1'b1) begin failures++; $display("FAIL ldf_dm_ready got=%h want=1", dm_ready2); end
        checks++; if (dm_rdata2 !== 32'h6A5A_3000) begin failures++; $display("FAIL ldf_dm_rdata got=%h want=6a5a3000", dm_rdata2); end
        dm_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_2000; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk); // t+1
    checks++; if (mem_en2 !== 1'b1 || mem_we2 !== 1'b1) begin failures++; $display("FAIL st_access got en=%h we=%h want 1 1", mem_en2, mem_we2); end
    checks++; if (mem_addr2 !== 32'h0000_2000 || mem_wdata2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL st_bus got addr=%h wdata=%h want 00002000 deadbeef", mem_addr2, mem_wdata2); end
    @(negedge clk); // t+2
    checks++; if (dm_ready2 !== 1'b1 || mem_en2 !== 1'b0) begin failures++; $display("FAIL st_ready got rdy=%h en=%h want 1 0", dm_ready2, mem_en2); end
    checks++; if (dm_rdata2 !== 32'h6A5A_3000) begin failures++; $display("FAIL st_rdata_kept got=%h want=6a5a3000", dm_rdata2); end
    dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk); // t+3
    checks++; if (dm_ready2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL st_t3 got rdy=%h busy=%h want 0 0", dm_ready2, busy2); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_dm;
    int g;
    int r;
    exp_dm = 10'b0111101111; // bit g set = grant g goes to data
    g = 0; r = 0;
    if_addr = 32'h0000_0400; dm_addr = 32'h0000_8000; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int c = 0; c < 200 && r < 10; c++) begin
      @(negedge clk);
      if (mem_en2) begin
        if (g < 10) begin
          checks++; if (mem_addr2[15] !== exp_dm[g]) begin failures++; $display("FAIL b2b_grant g=%0d got_dm=%h want_dm=%h", g, mem_addr2[15], exp_dm[g]); end
        end
        g++;
      end
      if (if_ready2) begin
        checks++; if (if_rdata2 !== ram_word(if_addr)) begin failures++; $display("FAIL b2b_if_rdata got=%h want=%h", if_rdata2, ram_word(if_addr)); end
        if_addr = if_addr + 32'd4;
        r++;
      end
      if (dm_ready2) begin
        checks++; if (dm_rdata2 !== ram_word(dm_addr)) begin failures++; $display("FAIL b2b_dm_rdata got=%h want=%h", dm_rdata2, ram_word(dm_addr)); end
        dm_addr = dm_addr + 32'd4;
        r++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    checks++; if (g != 10 || r != 10) begin failures++; $display("FAIL b2b_count got grants=%0d readies=%0d want 10 10", g, r); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    logic exp_rdy;
    if_addr = 32'h0000_0500; if_req = 1'b1;
    @(negedge clk); // t+1 ACCESS
    @(negedge clk); // t+2 WAIT
    rst = 1'b1;
    @(negedge clk); // t+3
    checks++; if (mem_en2 !== 1'b0 || mem_we2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl got en=%h we=%h busy=%h want 0 0 0", mem_en2, mem_we2, busy2); end
    checks++; if (mem_addr2 !== 32'h0 || mem_wdata2 !== 32'h0) begin failures++; $display("FAIL rst_mid_bus got addr=%h wdata=%h want 0 0", mem_addr2, mem_wdata2); end
    checks++; if (if_rdata2 !== 32'h0 || dm_rdata2 !== 32'h0 || if_ready2 !== 1'b0 || dm_ready2 !== 1'b0) begin failures++; $display("FAIL rst_mid_data got if=%h dm=%h rdy=%h%h want zeros", if_rdata2, dm_rdata2, if_ready2, dm_ready2); end
    checks++; if (sel_stall2 !== 1'b1) begin failures++; $display("FAIL rst_mid_stall got=%h want=1", sel_stall2); end
    rst = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      exp_rdy = (k == 7);
      checks++; if (if_ready2 !== exp_rdy) begin failures++; $display("FAIL rst_reissue_ready k=%0d got=%h want=%h", k, if_ready2, exp_rdy); end
      if (k == 4) begin
        checks++; if (mem_en2 !== 1'b1 || mem_addr2 !== 32'h0000_0500) begin failures++; $display("FAIL rst_reissue_access got en=%h addr=%h want 1 00000500", mem_en2, mem_addr2); end
      end
      if (k == 7) begin
        checks++; if (if_rdata2 !== 32'h5F5A_0500) begin failures++; $display("FAIL rst_reissue_rdata got=%h want=5f5a0500", if_rdata2); end
        if_req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_latency_sweep();
    int f1, f2, f7;
    logic [31:0] r1, r2, r7;
    f1 = 0; f2 = 0; f7 = 0; r1 = '0; r2 = '0; r7 = '0;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_addr = 32'h0000_0600; if_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (if_ready1 && f1 == 0) begin f1 = k; r1 = if_rdata1; end
      if (if_ready2 && f2 == 0) begin f2 = k; r2 = if_rdata2; end
      if (if_ready7 && f7 == 0) begin f7 = k; r7 = if_rdata7; end
    end
    if_req = 1'b0;
    checks++; if (f1 != 3) begin failures++; $display("FAIL sweep_l1_cycle got=%0d want=3", f1); end
    checks++; if (r1 !== 32'h5C5A_0600) begin failures++; $display("FAIL sweep_l1_rdata got=%h want=5c5a0600", r1); end
    checks++; if (f2 != 4) begin failures++; $display("FAIL sweep_l2_cycle got=%0d want=4", f2); end
    checks++; if (r2 !== 32'h5C5A_0600) begin failures++; $display("FAIL sweep_l2_rdata got=%h want=5c5a0600", r2); end
    checks++; if (f7 != 9) begin failures++; $display("FAIL sweep_l7_cycle got=%0d want=9", f7); end
    checks++; if (r7 !== 32'h5C5A_0600) begin failures++; $display("FAIL sweep_l7_rdata got=%h want=5c5a0600", r7); end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_load_during_fetch();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-port unified memory shared by the instruction-fetch stage and the memory stage (LDR/STR). Accepts one request per requester with a hold-until-ready handshake and grants the port to one of them, with data-over-fetch priority and a bounded starvation guard. Drives the RAM through a fixed-latency read sequence and pulses a per-requester ready. Generates the pipeline stall that feeds the stage units' `sel_stall`.

## Interface
- MEM_LATENCY, 2, RAM read latency in cycles; legal range 1..7
- MAX_DM_STREAK, 4, max consecutive data grants while fetch is waiting; legal range 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch read request, held until if_ready
- if_addr  in  32  fetch address, stable while if_req
- if_ready  out  1  one-cycle pulse, if_rdata valid this cycle
- if_rdata  out  32  fetched word (registered, holds until next fetch completion)
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = store, 0 = load; stable while dm_req
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_ready  out  1  one-cycle pulse on completion
- dm_rdata  out  32  load word (registered, holds)
- mem_en  out  1  RAM access strobe, exactly one cycle per transaction
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  32  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid MEM_LATENCY cycles after the mem_en cycle
- sel_stall  out  1  pipeline stall request
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If no request, stay.
  - Otherwise latch the winner (owner, we, addr, wdata) and go to ACCESS.
- Arbitration, evaluated only in IDLE:
  - If only one request, grant it.
  - If both: grant data unless streak == MAX_DM_STREAK, then grant fetch.
- streak, 4-bit:
  - +1 on each data grant made while if_req is high.
  - Cleared on any fetch grant, or on a data grant with if_req low.
  - Saturates at MAX_DM_STREAK.
- ACCESS, one cycle:
  - mem_en=1, mem_we=latched we (0 for fetch), mem_addr/mem_wdata from latches.
  - Write goes to DONE; read goes to WAIT with counter = MEM_LATENCY.
- WAIT:
  - Decrement counter.
  - In the cycle the counter equals 1, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE, one cycle: pulse the owner's ready, return to IDLE.
  - A request still high in the following cycle is a new transaction.
- Store completion does not alter dm_rdata.
- mem_en, mem_we and ready are 0 outside the states listed above. mem_addr/mem_wdata hold their last values.
- sel_stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
- Requester dropping req mid-transaction is illegal. The arbiter completes the transaction and still pulses ready.
- rst, including mid-transaction:
  - State returns to IDLE and the in-flight access is abandoned.
  - All outputs 0: mem_*, if_ready, dm_ready, if_rdata, dm_rdata, busy.
  - streak = 0.
  - sel_stall follows its equation.

## Timing
- Request first high in cycle t (arbiter idle): ACCESS in t+1.
- Read: WAIT t+2..t+1+MEM_LATENCY, ready in t+2+MEM_LATENCY. Latency is MEM_LATENCY+2 cycles.
- Write: ready in t+2, latency 2 cycles.
- Back-to-back: the next grant is decided in the IDLE cycle after DONE.
  - Minimum spacing between mem_en pulses is 3 cycles (writes) or MEM_LATENCY+3 cycles (reads).
- A request arriving while busy waits. Its latency counts from the cycle the arbiter reaches IDLE.
- Simultaneous if_req/dm_req rise in IDLE: the priority rule decides, and the loser sees sel_stall.

## Test plan
- Single fetch, MEM_LATENCY=2, if_addr=0x100, RAM returns 0xE3A01005:
  - mem_en exactly in t+1 with mem_we=0.
  - if_ready pulse in t+4 with if_rdata=0xE3A01005.
  - sel_stall high t..t+3, low in t+4.
- Store dm_we=1, addr=0x2000, wdata=0xDEADBEEF:
  - mem_en/mem_we high in t+1 with that addr/data.
  - dm_ready in t+2; dm_rdata unchanged.
- Both requests held continuously, MAX_DM_STREAK=4:
  - Grant order: D,D,D,D,F,D,D,D,D,F.
  - Each if_rdata/dm_rdata matches the RAM model.
- Load during an in-flight fetch:
  - dm_req rises in the fetch's WAIT cycle.
  - Fetch completes first; the data ACCESS follows the next IDLE cycle.
  - No overlapping mem_en.
- rst asserted in WAIT of a read:
  - Next cycle all outputs are 0 and state is IDLE.
  - No ready pulse for the aborted read.
  - With requests still held after rst deasserts, the arbiter re-arbitrates and the reissued read completes normally.
- Sweep MEM_LATENCY=1 and 7:
  - Read ready lands exactly at t+3 and t+9.
  - Captured data equals the word the model drives at that latency.
